// File: rtl/round_sequencer_pkg.sv
// Shared constants and state type for the 80-round message scheduler sequencer.
package round_sequencer_pkg;

   localparam int ROUNDS     = 80;
   localparam int LOAD_WORDS = 16;
   localparam int PHASE_LEN  = 20;
   localparam int A_LATENCY  = 6;

   typedef enum logic [1:0] {
      IDLE,
      PRE,
      RUN,
      DRAIN
   } state_t;

   // Rounds 19, 39 and 59 precede a phase change seen one stage later.
   function automatic logic is_phase_end(input logic [6:0] r);
      return (r == 7'(PHASE_LEN - 1)) || (r == 7'(2 * PHASE_LEN - 1)) ||
             (r == 7'(3 * PHASE_LEN - 1));
   endfunction

endpackage

// File: rtl/round_sequencer_pulse_delay.sv
// N-stage single-bit shift register with synchronous clear.
module pulse_delay #(
   parameter int N = 6
) (
   input  logic clk,
   input  logic clear,
   input  logic din,
   output logic dout
);

   logic [N-1:0] taps;

   always_ff @(posedge clk) begin
      if (clear) begin
         taps <= '0;
      end else begin
         taps <= {taps[N-2:0], din};
      end
   end

   assign dout = taps[N-1];

endmodule

// File: rtl/round_sequencer.sv
// Round sequencer: steps rounds 0..79 per accepted block and flags the final
// A value after the datapath latency; back-to-back blocks run without a bubble.
module round_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_valid,
   output logic       start_ready,
   output logic       word_rd,
   output logic       load6,
   output logic       phase_advance7,
   output logic [6:0] round,
   output logic       busy,
   output logic       result_valid
);

   import round_sequencer_pkg::*;

   state_t     state;
   state_t     state_next;
   logic [6:0] round_q;
   logic [6:0] round_next;
   logic       last_round;
   logic       accept;

   assign last_round  = (state == RUN) && (round_q == 7'(ROUNDS - 1));
   // Reset wins over a simultaneous request, so readiness is masked by rst.
   assign start_ready = !rst && ((state == IDLE) || (state == DRAIN) || last_round);
   assign accept      = start_valid && start_ready;

   always_comb begin
      state_next     = state;
      round_next     = round_q;
      phase_advance7 = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               phase_advance7 = 1'b1;
               state_next     = RUN;
               round_next     = '0;
            end
         end
         PRE: begin
            phase_advance7 = 1'b1;
            state_next     = RUN;
            round_next     = '0;
         end
         RUN: begin
            if (last_round) begin
               round_next = '0;
               if (accept) begin
                  phase_advance7 = 1'b1;
               end else begin
                  state_next = DRAIN;
               end
            end else begin
               round_next     = round_q + 7'd1;
               phase_advance7 = is_phase_end(round_q);
            end
         end
         DRAIN: begin
            // A request here still needs its phase_advance7 cycle before round 0.
            if (accept) begin
               state_next = PRE;
            end else if (result_valid) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            round_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         round_q <= '0;
      end else begin
         state   <= state_next;
         round_q <= round_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (round_q <= 7'(ROUNDS - 1));
      end
   end

   assign load6   = (state == RUN) && (round_q < 7'(LOAD_WORDS));
   assign word_rd = load6;
   assign round   = round_q;
   assign busy    = (state != IDLE);

   // One pulse per round-79 cycle, so overlapping blocks each get their own.
   pulse_delay #(
      .N(A_LATENCY)
   ) u_result_delay (
      .clk  (clk),
      .clear(rst),
      .din  (last_round),
      .dout (result_valid)
   );

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-high, named rst.
REQ-002 Port: clk  in  1  rising-edge clock for all state.
REQ-003 Port: rst  in  1  synchronous active-high reset.
REQ-004 Port: start_valid  in  1  requester has a 512-bit block ready to stream.
REQ-005 Port: start_ready  out  1  block accepted on the cycle where start_valid && start_ready.
REQ-006 Port: word_rd  out  1  source SHALL present the next 32-bit message word on Din in the following cycle.
REQ-007 Port: load6  out  1  drives the control generator's load6 input.
REQ-008 Port: phase_advance7  out  1  drives the control generator's phase_advance7 input.
REQ-009 Port: round  out  7  current stage-6 round index, 0..79; 0 when idle.
REQ-010 Port: busy  out  1  high from acceptance until result_valid is asserted.
REQ-011 Port: result_valid  out  1  one-cycle pulse: A holds the final round-79 value this cycle.

Function
REQ-012 FSM states: IDLE, PRE, RUN, DRAIN.
REQ-013 IDLE: start_ready=1; on handshake assert phase_advance7 this cycle, go to RUN with round=0 next cycle.
- Covers PRE; the PRE state is entered only in a back-to-back case, see REQ-017.
REQ-014 RUN: round increments by 1 each cycle from 0 to 79; no stalls.
- load6 = word_rd = (round < 16).
REQ-015 phase_advance7 SHALL be asserted when round is 19, 39 or 59, so phase_advance6 coincides with rounds 20, 40 and 60.
REQ-016 Round 0 SHALL always see load6=1 and phase_advance6=1 together, which resets the phase to 0.
REQ-017 At round 79, start_ready=1.
- If start_valid=1: assert phase_advance7 and continue RUN at round=0 with zero bubble.
- Else: go to DRAIN.
REQ-018 DRAIN: wait until result_valid fires, then go to IDLE.
- A start_valid arriving in DRAIN SHALL be accepted (start_ready=1) and SHALL go through PRE (phase_advance7=1, one cycle), then RUN round 0.
REQ-019 result_valid SHALL pulse exactly 6 cycles after the round-79 cycle, matching the Din-to-A latency.
- Implemented with a 6-deep delay line so that overlapping blocks each produce their own pulse.
REQ-020 start_ready SHALL be 0 in RUN for rounds 0..78.
REQ-021 phase_advance7 SHALL never be asserted on two consecutive cycles.
REQ-022 The round counter SHALL not wrap past 79.
- Any value above 79 is unreachable; assertion check.

Reset
REQ-023 When rst=1, next state SHALL be IDLE.
- round=0; load6, word_rd, phase_advance7, result_valid and busy SHALL be 0.
- start_ready SHALL be 0 during reset and 1 on the first cycle after it.
REQ-024 Reset mid-block SHALL abandon the block with no result_valid pulse.
- The delay line SHALL be cleared.
REQ-025 rst SHALL take priority over a simultaneous start_valid.

Structure
REQ-026 A shared package SHALL hold: ROUNDS=80, LOAD_WORDS=16, PHASE_LEN=20, A_LATENCY=6, and the state enum type.
REQ-027 One sub-module, pulse_delay, SHALL be used: a parameterised N-stage 1-bit shift register with synchronous clear, instantiated with N=A_LATENCY.

Verification
REQ-028 Single block: reset, then start_valid at cycle 10.
- Required: word_rd/load6 high in cycles 11..26.
- phase_advance7 in cycles 10, 30, 50, 70.
- result_valid at cycle 96.
- busy falls after cycle 96.
REQ-029 Back-to-back blocks: start_valid held high.
- Required: second acceptance at round 79.
- Second round 0 on the next cycle, with no gap in load6.
- Two result_valid pulses exactly 80 cycles apart.
REQ-030 Start in DRAIN: second start_valid 3 cycles after round 79.
- Required: one PRE cycle, then RUN.
- First result_valid is still emitted on time.
REQ-031 Reset at round 45.
- Required: all outputs 0 next cycle; no result_valid ever pulses for that block.
- A new start is accepted 1 cycle after reset deasserts.
REQ-032 Compliance with the control generator and datapath: run the pair with the "abc" padded block.
- Required: A at result_valid, combined with the IV chaining, yields digest a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d.
